// File: rtl/rf_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Shared widths, writeback bus field offsets and helpers for the
//                register-file write arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int RF_BUS_W     = 38;
    localparam int REG_ADDR_W   = 5;
    localparam int DATA_W       = 32;

    // Writeback bus layout: {we, waddr[4:0], wdata[31:0]}
    localparam int BUS_WE_BIT   = 37;
    localparam int BUS_ADDR_LSB = 32;
    localparam int BUS_DATA_LSB = 0;

    // Divider FIFO entry layout: {waddr, wdata}
    localparam int ENTRY_W      = REG_ADDR_W + DATA_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
    } div_entry_t;

    // One-hot decode of an architectural register number
    function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        reg_onehot = 32'd1 << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wr_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO buffering divider results. Pointers wrap
//                modulo DEPTH, occupancy is held in a separate counter, and the
//                tag field of every live slot is exported for hazard masks.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int DEPTH   = 2,
    parameter int WIDTH   = 37,
    parameter int TAG_LSB = 32,
    parameter int TAG_W   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH-1:0]       slot_valid_o,
    output logic [DEPTH*TAG_W-1:0] slot_tags_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // A slot is live when its distance from the read pointer is below the occupancy
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam logic [AW-1:0] IDX = AW'(i);
        logic [AW-1:0] w_off;
        assign w_off           = IDX - rd_ptr_q;
        assign slot_valid_o[i] = ({1'b0, w_off} < count_q);
        assign slot_tags_o[i*TAG_W +: TAG_W] = mem_q[i][TAG_LSB +: TAG_W];
    end

endmodule
`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wr_arbiter
//  Description : Shares the register-file write port between the in-order
//                writeback stage (priority) and buffered out-of-order divider
//                results, with a starvation counter that forces the oldest
//                divider result through. Exports a pending-destination mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_arbiter
    import cpu_defs::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RF_BUS_W-1:0]   ws_rf_bus,
    output logic                  ws_hold,
    input  logic                  div_valid,
    output logic                  div_ready,
    input  logic [REG_ADDR_W-1:0] div_waddr,
    input  logic [DATA_W-1:0]     div_wdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [31:0]           div_pend_mask,
    output logic                  wr_collide
);

    localparam int              CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic                        w_ws_we;
    logic [REG_ADDR_W-1:0]       w_ws_waddr;
    logic [DATA_W-1:0]           w_ws_wdata;
    logic                        w_ws_req;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [ENTRY_W-1:0]          w_head_raw;
    div_entry_t                  w_head;
    logic [FIFO_DEPTH-1:0]       w_slot_valid;
    logic [FIFO_DEPTH*REG_ADDR_W-1:0] w_slot_tags;

    logic                        w_grant_ws;
    logic                        w_grant_head;
    logic                        w_drop;
    logic [CNT_W-1:0]            w_wait_inc;

    assign w_ws_we    = ws_rf_bus[BUS_WE_BIT];
    assign w_ws_waddr = ws_rf_bus[BUS_ADDR_LSB +: REG_ADDR_W];
    assign w_ws_wdata = ws_rf_bus[BUS_DATA_LSB +: DATA_W];
    assign w_ws_req   = w_ws_we && (w_ws_waddr != '0);

    // Readiness comes from registered occupancy only; a same-cycle pop is not credited
    assign div_ready = !w_full;
    // Writes to r0 are architecturally void, so they never occupy a slot
    assign w_push    = div_valid && div_ready && (div_waddr != '0);
    assign w_pop     = w_grant_head || w_drop;
    assign w_head    = div_entry_t'(w_head_raw);

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (ENTRY_W),
        .TAG_LSB (DATA_W),
        .TAG_W   (REG_ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (w_push),
        .push_data_i  ({div_waddr, div_wdata}),
        .pop_i        (w_pop),
        .head_o       (w_head_raw),
        .full_o       (w_full),
        .empty_o      (w_empty),
        .slot_valid_o (w_slot_valid),
        .slot_tags_o  (w_slot_tags)
    );

    // Port arbitration: writeback wins in NORMAL, FIFO head owns the port in FORCE
    always_comb begin
        w_grant_ws   = 1'b0;
        w_grant_head = 1'b0;
        w_drop       = 1'b0;
        if (state_q == ST_FORCE) begin
            w_grant_head = !w_empty;
        end else if (w_ws_req) begin
            w_grant_ws = 1'b1;
            // Writeback is later in program order, so an older result to the same register is stale
            w_drop     = !w_empty && (w_head.waddr == w_ws_waddr);
        end else begin
            w_grant_head = !w_empty;
        end
    end

    // Drive the write port from the granted source, zero when idle
    always_comb begin
        rf_we    = w_grant_ws || w_grant_head;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_grant_ws) begin
            rf_waddr = w_ws_waddr;
            rf_wdata = w_ws_wdata;
        end else if (w_grant_head) begin
            rf_waddr = w_head.waddr;
            rf_wdata = w_head.wdata;
        end
    end

    assign wr_collide = w_drop;
    assign w_wait_inc = wait_q + 1'b1;

    // Starvation tracking: count lost cycles of a nonempty FIFO, force a grant on reaching the limit
    always_comb begin
        state_d = ST_NORMAL;
        wait_d  = '0;
        if ((state_q == ST_NORMAL) && !w_empty && !w_grant_head) begin
            if (w_wait_inc == MAX_WAIT_C) begin
                state_d = ST_FORCE;
            end else begin
                wait_d = w_wait_inc;
            end
        end
    end

    // FSM and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // The hold is taken straight from the state flop, so it is registered
    assign ws_hold = (state_q == ST_FORCE);

    // Pending-destination mask: OR of one-hot destinations of live FIFO slots
    always_comb begin
        div_pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_slot_valid[i]) begin
                div_pend_mask = div_pend_mask | reg_onehot(w_slot_tags[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wr_arbiter
//  Description : Directed-vector bench for rf_wr_arbiter. Expected regfile
//                writes are queued as stimulus is issued; a negedge monitor
//                pops and compares every write the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] ws_rf_bus = '0;
    logic        div_valid = 1'b0;
    logic [4:0]  div_waddr = '0;
    logic [31:0] div_wdata = '0;

    logic        ws_hold;
    logic        div_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] div_pend_mask;
    logic        wr_collide;

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_q [$];
    logic [36:0] mon_e;

    rf_wr_arbiter #(
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ws_rf_bus     (ws_rf_bus),
        .ws_hold       (ws_hold),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_waddr     (div_waddr),
        .div_wdata     (div_wdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .div_pend_mask (div_pend_mask),
        .wr_collide    (wr_collide)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic ws(input logic we, input logic [4:0] a, input logic [31:0] d);
        ws_rf_bus = {we, a, d};
    endtask

    task automatic div(input logic v, input logic [4:0] a, input logic [31:0] d);
        div_valid = v;
        div_waddr = a;
        div_wdata = d;
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every presented write must match the oldest expectation; idle port must be zero
    always @(negedge clk) begin
        checks++;
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== mon_e) begin
                    failures++;
                    $display("FAIL rf_write: got r%0d=0x%0h expected r%0d=0x%0h",
                             rf_waddr, rf_wdata, mon_e[36:32], mon_e[31:0]);
                end
            end
        end else if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            failures++;
            $display("FAIL idle_port: got we=%b r%0d=0x%0h expected we=0 r0=0x0", rf_we, rf_waddr, rf_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) step();
        neg();
        chk("rst_ws_hold", ws_hold, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_div_ready", div_ready, 1);
        chk("rst_mask", div_pend_mask, 0);
        chk("rst_collide", wr_collide, 0);
        step(); reset = 1'b0;
        neg();

        // T1: single divider result, ws idle
        step(); div(1, 5'd5, 32'h1234);
        neg(); chk("t1_no_bypass", rf_we, 0);
        step(); div(0, 0, 0); exp_wr(5'd5, 32'h1234);
        neg(); chk("t1_mask_set", div_pend_mask, 32'd1 << 5);
        step();
        neg(); chk("t1_mask_clear", div_pend_mask, 0);

        // T2: ws busy on r3 while r7 waits; forced grant after four lost cycles
        step(); ws(1, 5'd3, 32'hAAAA); div(1, 5'd7, 32'h77); exp_wr(5'd3, 32'hAAAA);
        neg();
        for (int k = 1; k <= 4; k++) begin
            step(); div(0, 0, 0); exp_wr(5'd3, 32'hAAAA);
            neg(); chk("t2_hold_low", ws_hold, 0);
        end
        step(); exp_wr(5'd7, 32'h77);
        neg(); chk("t2_hold_force", ws_hold, 1);
        step(); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t2_hold_release", ws_hold, 0);
        chk("t2_mask_empty", div_pend_mask, 0);
        step(); ws(0, 0, 0);
        neg();

        // T3: fill FIFO with ws busy, third result stalls until a pop
        step(); ws(1, 5'd3, 32'hAAAA); div(1, 5'd10, 32'hA0); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t3_ready_c0", div_ready, 1);
        step(); div(1, 5'd11, 32'hB0); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t3_ready_c1", div_ready, 1);
        step(); div(1, 5'd12, 32'hC0); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t3_full", div_ready, 0);
        chk("t3_mask_full", div_pend_mask, (32'd1 << 10) | (32'd1 << 11));
        step(); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t3_full_c3", div_ready, 0);
        step(); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t3_hold_c4", ws_hold, 0);
        step(); exp_wr(5'd10, 32'hA0);
        neg(); chk("t3_hold_force", ws_hold, 1);
        chk("t3_pop_not_credited", div_ready, 0);
        step(); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t3_ready_after_pop", div_ready, 1);
        step(); div(0, 0, 0); ws(0, 0, 0); exp_wr(5'd11, 32'hB0);
        neg(); chk("t3_mask_c7", div_pend_mask, (32'd1 << 11) | (32'd1 << 12));
        step(); exp_wr(5'd12, 32'hC0);
        neg();
        step();
        neg(); chk("t3_mask_drained", div_pend_mask, 0);

        // T4: collision on r9, head dropped
        step(); div(1, 5'd9, 32'h2);
        neg();
        step(); div(0, 0, 0); ws(1, 5'd9, 32'h1); exp_wr(5'd9, 32'h1);
        neg(); chk("t4_collide", wr_collide, 1);
        chk("t4_mask_set", div_pend_mask, 32'd1 << 9);
        step(); ws(0, 0, 0);
        neg(); chk("t4_collide_end", wr_collide, 0);
        chk("t4_mask_clear", div_pend_mask, 0);

        // T5: writes to r0 from both sources are ignored
        step(); div(1, 5'd0, 32'h55); ws(1, 5'd0, 32'h66);
        neg(); chk("t5_no_we", rf_we, 0);
        chk("t5_ready", div_ready, 1);
        step(); div(0, 0, 0); ws(0, 0, 0);
        neg(); chk("t5_mask", div_pend_mask, 0);
        chk("t5_no_we_after", rf_we, 0);

        // T6: reset while in FORCE with two entries buffered
        step(); ws(1, 5'd3, 32'hAAAA); div(1, 5'd20, 32'h20); exp_wr(5'd3, 32'hAAAA);
        neg();
        step(); div(1, 5'd21, 32'h21); exp_wr(5'd3, 32'hAAAA);
        neg();
        step(); div(0, 0, 0); exp_wr(5'd3, 32'hAAAA);
        neg(); chk("t6_full", div_ready, 0);
        step(); exp_wr(5'd3, 32'hAAAA);
        neg();
        step(); exp_wr(5'd3, 32'hAAAA);
        neg();
        step(); reset = 1'b1; exp_wr(5'd20, 32'h20);
        neg(); chk("t6_in_force", ws_hold, 1);
        chk("t6_mask_two", div_pend_mask, (32'd1 << 20) | (32'd1 << 21));
        step(); reset = 1'b0; ws(0, 0, 0);
        neg(); chk("t6_hold_cleared", ws_hold, 0);
        chk("t6_mask_cleared", div_pend_mask, 0);
        chk("t6_ready", div_ready, 1);
        chk("t6_no_we", rf_we, 0);

        step();
        neg(); chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
